ula_serial_seq: RTL
===================

// Module: ula_serial_seq
// PURPOSE
//  Bit-serial sequencer wrapped around a 1-bit ULA slice. Latches two WIDTH-bit operands and an op,
//  then streams them LSB-first through the slice, one bit per clock, with a registered carry.
//  Assembles the WIDTH-bit result plus flags. Sits between the operand source (register-file
//  read / ID stage) and the result writeback of the MIPS datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal range 2..64
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request pulse, sampled only in IDLE
//  op       in   2      00 AND, 01 OR, 10 ADD, 11 SUB (ula_pkg::ula_op_t)
//  a        in   WIDTH  operand A, sampled with start
//  b        in   WIDTH  operand B, sampled with start
//  busy     out  1      high in RUN and DONE
//  done     out  1      one-cycle pulse: result/flags valid from this cycle on
//  result   out  WIDTH  last completed result; held until the next accepted start completes
//  zero     out  1      result == 0, updated together with result
//  carry    out  1      carry out of the MSB (ADD/SUB); 0 for AND/OR
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, result, zero, carry = 0; internal regs cleared.
//    Reset mid-operation aborts immediately, with no done pulse.
//  FSM:
//    IDLE: start=1 -> latch a, b, op; cnt=0; cin=(op==SUB); go RUN
//    RUN: every cycle slice processes bit cnt
//      - b bit inverted for SUB (a + ~b + 1)
//      - sum/logic bit shifted into shadow result at position cnt; cin <= slice carry-out
//      - cnt == WIDTH-1 -> go DONE
//    DONE: copy shadow to result; set zero/carry; done=1 for this cycle only; go IDLE
//  Latency: start sampled at edge N -> done high during cycle N+WIDTH+1; throughput one op per
//    WIDTH+2 cycles.
//  start while busy: ignored, no queuing. Operand changes after the start edge have no effect.
//  Arithmetic: modulo 2^WIDTH wrap-around.
//    - ADD: carry = unsigned overflow.
//    - SUB: carry = NOT borrow, so a>=b unsigned gives carry=1.
//  result/zero/carry change only in DONE; a new start does not clear them.
// CONFIGURATION
//  ULA_SEQ_OVF_EN defined:
//    - adds output port ovf (1 bit), reset 0, updated in DONE.
//    - ADD/SUB: ovf = signed overflow (carry into MSB XOR carry out of MSB).
//    - AND/OR: ovf = 0.
//  ULA_SEQ_OVF_EN undefined: port ovf and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  ula_pkg:
//    - ula_op_t enum (OP_AND, OP_OR, OP_ADD, OP_SUB)
//    - seq_state_t enum (S_IDLE, S_RUN, S_DONE)
//  Sub-module ula_bit_slice: combinational 1-bit AND/OR/full-add cell.
//    Ports: a, b, cin, op -> y, cout.
//    Instantiated once; the sequencer owns all registers (operand shift regs, cnt, cin, shadow).
// TESTING (WIDTH=8 unless noted)
//  1. ADD a=0x05, b=0x03, start pulse:
//     -> busy next cycle; done 9 cycles after start edge; result=0x08, zero=0, carry=0
//  2. SUB a=0x03, b=0x05:
//     -> result=0xFE, carry=0; then SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry=1
//  3. ADD a=0xFF, b=0x01:
//     -> result=0x00, zero=1, carry=1
//     With ULA_SEQ_OVF_EN: ADD 0x7F+0x01 -> result=0x80, ovf=1
//  4. AND 0xF0&0x3C -> 0x30; OR 0xF0|0x0F -> 0xFF, carry=0.
//     WIDTH=32: ADD 0xFFFFFFFF+1 -> 0, carry=1
//  5. start with a=0x10, b=0x01 (ADD); re-pulse start with other operands during RUN:
//     -> second start ignored; single done; result=0x11
//  6. rst_n low 4 cycles into an op:
//     -> outputs 0 immediately, no done; next start (ADD 1+1) completes with result=0x02

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types for the bit-serial ULA sequencer: op encoding and sequencer states.
package ula_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } ula_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_t;

  function automatic logic is_arith(input ula_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ula_bit_slice.sv
// Combinational 1-bit ULA cell: AND, OR or full add; subtraction is handled by the caller
// inverting b and seeding cin.
module ula_bit_slice
  import ula_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  ula_op_t op,
  output logic    y,
  output logic    cout
);

  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: begin
        y    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
    endcase
  end

endmodule

// File: rtl/ula_serial_seq.sv
// Bit-serial sequencer around ula_bit_slice: one operand bit per clock, LSB first.
// Optional signed-overflow output enabled by defining ULA_SEQ_OVF_EN.
module ula_serial_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ULA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             carry
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  seq_state_t       state_reg;
  ula_op_t          op_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             cin_reg;
`ifdef ULA_SEQ_OVF_EN
  logic             msb_cin_reg;
`endif

  logic slice_b;
  logic slice_y;
  logic slice_cout;

  // SUB is a + ~b + 1: b inverted here, the +1 comes from the seeded carry.
  assign slice_b = b_sh_reg[0] ^ (op_reg == OP_SUB);

  ula_bit_slice u_slice (
    .a    (a_sh_reg[0]),
    .b    (slice_b),
    .cin  (cin_reg),
    .op   (op_reg),
    .y    (slice_y),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      op_reg      <= OP_AND;
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      shadow_reg  <= '0;
      cnt_reg     <= '0;
      cin_reg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
`ifdef ULA_SEQ_OVF_EN
      msb_cin_reg <= 1'b0;
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            op_reg     <= ula_op_t'(op);
            cnt_reg    <= '0;
            cin_reg    <= (ula_op_t'(op) == OP_SUB);
            shadow_reg <= '0;
            busy       <= 1'b1;
            state_reg  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          // Shift in from the top so bit 0 lands at position 0 after WIDTH cycles.
          shadow_reg <= {slice_y, shadow_reg[WIDTH-1:1]};
          cin_reg    <= slice_cout;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST) begin
`ifdef ULA_SEQ_OVF_EN
            msb_cin_reg <= cin_reg;
`endif
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          result    <= shadow_reg;
          zero      <= (shadow_reg == '0);
          carry     <= is_arith(op_reg) & cin_reg;
`ifdef ULA_SEQ_OVF_EN
          ovf       <= is_arith(op_reg) & (msb_cin_reg ^ cin_reg);
`endif
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
